register_file: RTL and testbench
================================

Name: register_file

Overview:
- General-purpose register file for the 16-bit 5-stage pipelined datapath. It holds 16 registers of 16 bits each.
- Provides two combinational read ports, one primary write port and one secondary write port. The secondary port writes a second result in the same cycle, e.g. the upper half of a multiply/divide.
- Register R15 is also exported continuously for use by the datapath.

Parameters:
- DATA_WIDTH, 16, width of each register and of all data ports.
- ADDR_WIDTH, 4, register address width; register count = 2**ADDR_WIDTH = 16.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous active-low reset; clears all registers.
- ReadReg1  input  4  read port 1 address.
- ReadReg2  input  4  read port 2 address.
- WriteReg1  input  4  write port 1 address.
- WriteReg2  input  4  write port 2 address.
- WriteData1  input  16  write port 1 data.
- WriteData2  input  16  write port 2 data.
- RegWrite  input  1  global write enable; enables port 1, and is required for port 2.
- WriteOP2  input  1  port 2 enable; effective only when RegWrite=1.
- ReadData1  output  16  contents addressed by ReadReg1.
- ReadData2  output  16  contents addressed by ReadReg2.
- R15  output  16  stored contents of register 15.

Behaviour:
- Reset: while rst=0, all 16 registers are held at 0x0000, asynchronously and immediately, independent of clk. ReadData1, ReadData2 and R15 therefore read 0x0000 during reset. A write edge occurring while rst=0 is ignored.
- Register 0 is an ordinary writable register (not hardwired to zero).
- Write timing, on each rising clk edge with rst=1:
  - RegWrite=1: reg[WriteReg1] <= WriteData1.
  - RegWrite=1 and WriteOP2=1: reg[WriteReg2] <= WriteData2.
  - RegWrite=0: no register changes, regardless of WriteOP2.
- Simultaneous writes to the same address (both ports enabled, WriteReg1==WriteReg2): port 2 wins and WriteData2 is stored.
- Reads are combinational (zero latency). ReadDataN reflects the addressed register's current stored value, changes with ReadRegN in the same cycle, and shows a newly written value immediately after the writing edge.
- No write-to-read bypass: during the cycle a write is pending, a read of the same address returns the old value. The datapath handles hazards by forwarding or by stalls.
- R15 always shows stored reg[15]. It updates after an edge that writes register 15 through either port, with the port-2 priority rule applied.
- Out-of-range addresses are impossible (4-bit address, 16 entries).
- Reset mid-operation: asserting rst between edges clears all contents at once. After release, the first rising edge with rst=1 performs normal writes.
- Unknown/X on RegWrite is a usage error; behaviour is unspecified and not verified.

Test Plan:
- Reset: hold rst=0 for 8 ns while clk toggles with RegWrite=1 -> all reads and R15 = 0x0000; no write takes effect.
- Dual write: rst=1, WriteReg1=0/WriteData1=0x0001, WriteReg2=10/WriteData2=0x0001, RegWrite=1, WriteOP2=1, one edge; then ReadReg1=0, ReadReg2=1 -> ReadData1=0x0001, ReadData2=0x0000; reading R10 gives 0x0001.
- Overwrite: write R1=0x0000 and R10=0x0000 on one edge (both enables set) -> R10 reads 0x0000, R0 still 0x0001.
- Enable gating: WriteOP2=1 with RegWrite=0, WriteReg1=3/WriteReg2=4, data 0xBEEF -> R3 and R4 unchanged at 0x0000. RegWrite=1 with WriteOP2=0 -> only R3 = 0xBEEF.
- Conflict and R15: WriteReg1=WriteReg2=15, WriteData1=0x1111, WriteData2=0x2222, both enabled -> R15=0x2222 after the edge, and ReadData1 with ReadReg1=15 = 0x2222.
- Async reset mid-run: after loading nonzero values, pulse rst=0 between clock edges -> all outputs read 0x0000 immediately, before the next edge.

Source files
------------

// File: rtl/register_file.sv
// 16 x 16-bit register file: two combinational read ports, two write ports
// (port 2 gated by RegWrite and winning on address conflict), R15 exported.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg1,
  input  logic [ADDR_WIDTH-1:0] WriteReg2,
  input  logic [DATA_WIDTH-1:0] WriteData1,
  input  logic [DATA_WIDTH-1:0] WriteData2,
  input  logic                  RegWrite,
  input  logic                  WriteOP2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] R15
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic hit1;
      logic hit2;

      assign hit1 = RegWrite && (WriteReg1 == ADDR_WIDTH'(gi));
      assign hit2 = RegWrite && WriteOP2 && (WriteReg2 == ADDR_WIDTH'(gi));

      // Port 2 is checked first so it takes priority on a shared address.
      always_comb begin
        regs_d[gi] = regs_q[gi];
        if (hit2) begin
          regs_d[gi] = WriteData2;
        end else if (hit1) begin
          regs_d[gi] = WriteData1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  assign ReadData1 = regs_q[ReadReg1];
  assign ReadData2 = regs_q[ReadReg2];
  assign R15       = regs_q[NUM_REGS-1];

endmodule

// File: tb/tb_register_file.sv
// Randomised scoreboard bench for register_file: the driver queues expected
// read-port values from an array model; a negedge monitor pops and compares.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  ReadReg1, ReadReg2, WriteReg1, WriteReg2;
  logic [15:0] WriteData1, WriteData2;
  logic        RegWrite, WriteOP2;
  logic [15:0] ReadData1, ReadData2, R15;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
    .WriteData1(WriteData1), .WriteData2(WriteData2),
    .RegWrite(RegWrite), .WriteOP2(WriteOP2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .R15(R15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] r15;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model [16];
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;

  task automatic push_exp(input string name);
    exp_t e;
    e.name = name;
    e.a1   = ReadReg1;
    e.a2   = ReadReg2;
    e.rd1  = model[ReadReg1];
    e.rd2  = model[ReadReg2];
    e.r15  = model[15];
    exp_q.push_back(e);
  endtask

  // One clock cycle of normal operation; expectations reflect contents before
  // this cycle's write, which lands on the following rising edge.
  task automatic do_cycle(input string name, input bit rw, input bit op2,
                          input logic [3:0] w1, input logic [15:0] d1,
                          input logic [3:0] w2, input logic [15:0] d2,
                          input logic [3:0] r1, input logic [3:0] r2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    RegWrite = rw; WriteOP2 = op2;
    WriteReg1 = w1; WriteData1 = d1;
    WriteReg2 = w2; WriteData2 = d2;
    ReadReg1 = r1; ReadReg2 = r2;
    push_exp(name);
    if (rw) begin
      model[w1] = d1;
      if (op2) model[w2] = d2;
    end
  endtask

  // Reset asserted between edges, held for n cycles with writes requested.
  task automatic reset_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      RegWrite = 1'b1; WriteOP2 = 1'b1;
      WriteReg1 = 4'($urandom); WriteData1 = 16'($urandom) | 16'h1;
      WriteReg2 = 15; WriteData2 = 16'hA5A5;
      ReadReg1 = 4'($urandom); ReadReg2 = 4'($urandom);
      for (int k = 0; k < 16; k++) model[k] = 16'h0;
      push_exp(name);
    end
  endtask

  task automatic check(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got 0x%04h expected 0x%04h", name, field, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "ReadData1", ReadData1, e.rd1);
        check(e.name, "ReadData2", ReadData2, e.rd2);
        check(e.name, "R15", R15, e.r15);
        $display("%s: rd1[%0d]=0x%04h rd2[%0d]=0x%04h r15=0x%04h",
                 e.name, e.a1, ReadData1, e.a2, ReadData2, R15);
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    bit rw, op2;
    logic [3:0] w1, w2;
    rst = 1'b0;
    RegWrite = 1'b1; WriteOP2 = 1'b1;
    WriteReg1 = 4'd5; WriteData1 = 16'hFFFF;
    WriteReg2 = 4'd15; WriteData2 = 16'h1234;
    ReadReg1 = 4'd5; ReadReg2 = 4'd15;
    for (int k = 0; k < 16; k++) model[k] = 16'h0;

    reset_cycles("reset_hold", 2);

    do_cycle("dual_write", 1, 1, 0, 16'h0001, 10, 16'h0001, 0, 1);
    do_cycle("dual_read",  0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1);
    do_cycle("read_r10",   0, 1, 0, 16'hDEAD, 0, 16'hDEAD, 10, 0);
    do_cycle("overwrite",  1, 1, 1, 16'h0000, 10, 16'h0000, 10, 0);
    do_cycle("ow_read",    0, 0, 0, 16'h0, 0, 16'h0, 10, 0);
    do_cycle("gate_off",   0, 1, 3, 16'hBEEF, 4, 16'hBEEF, 3, 4);
    do_cycle("gate_rd",    1, 0, 3, 16'hBEEF, 4, 16'hBEEF, 3, 4);
    do_cycle("gate_p1",    0, 0, 0, 16'h0, 0, 16'h0, 3, 4);
    do_cycle("conflict",   1, 1, 15, 16'h1111, 15, 16'h2222, 15, 3);
    do_cycle("conf_rd",    0, 0, 0, 16'h0, 0, 16'h0, 15, 3);
    reset_cycles("async_rst", 1);
    do_cycle("post_rst",   1, 0, 15, 16'h7777, 0, 16'h0, 15, 3);
    do_cycle("post_rd",    0, 0, 0, 16'h0, 0, 16'h0, 15, 3);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_cycles("rand_rst", 1);
      end else begin
        rw  = ($urandom_range(0, 3) != 0);
        op2 = $urandom_range(0, 1) == 1;
        w1  = 4'($urandom);
        w2  = ($urandom_range(0, 4) == 0) ? w1 : 4'($urandom);
        do_cycle("random", rw, op2, w1, 16'($urandom), w2, 16'($urandom),
                 4'($urandom), ($urandom_range(0, 3) == 0) ? w1 : 4'($urandom));
      end
    end

    do_cycle("final", 0, 0, 0, 16'h0, 0, 16'h0, 15, 0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
